// File: rtl/receptor_pkg.sv
// Shared definitions for the receptor receive path.
//   NUM_LANES   : number of physical lanes striped per word (4).
//   DK_*        : control_dk classification codes. They match the transmit mux's encoding.
//   rx_state_e  : classifier FSM states.
package receptor_pkg;

  localparam int unsigned NUM_LANES = 4;

  localparam int unsigned DK_DATA = 0;
  localparam int unsigned DK_COM  = 1;
  localparam int unsigned DK_SKP  = 2;
  localparam int unsigned DK_STP  = 3;
  localparam int unsigned DK_SDP  = 4;
  localparam int unsigned DK_END  = 5;
  localparam int unsigned DK_EDB  = 6;
  localparam int unsigned DK_FTS  = 7;
  localparam int unsigned DK_IDLE = 8;

  typedef enum logic [1:0] {
    StUnaligned,
    StAligned,
    StInPkt
  } rx_state_e;

endpackage

// File: rtl/receptor_byte_unstriping.sv
// Lane word holding register and byte drain.
// A captured word is drained one byte per enabled clock, lane 0 first. A word that arrives
// while bytes are still pending replaces them and raises a one-cycle overrun pulse.
// A word that arrives on the same edge as the last byte drains is back-to-back, not overrun.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   enb_i          : enable; low freezes all state, overrun_o goes 0 on the next edge
//   lanes_i        : lane k byte in slice [k]
//   lanes_valid_i  : strobe, lanes_i holds a new word
//   byte_o         : byte currently at the head of the buffer
//   byte_valid_o   : buffer holds an undrained byte
//   overrun_o      : registered pulse, pending bytes were dropped
module receptor_byte_unstriping
  import receptor_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enb_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]    lanes_i,
  input  logic                                lanes_valid_i,
  output logic [DATA_W-1:0]                   byte_o,
  output logic                                byte_valid_o,
  output logic                                overrun_o
);

  logic [NUM_LANES-1:0][DATA_W-1:0] hold_q, hold_d;
  logic [1:0]                       cnt_q, cnt_d;
  logic                             full_q, full_d;
  logic                             overrun_q, overrun_d;
  logic                             last;

  assign last = (cnt_q == 2'(NUM_LANES - 1));

  always_comb begin
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    overrun_d = 1'b0;
    if (enb_i) begin
      if (lanes_valid_i) begin
        hold_d    = lanes_i;
        cnt_d     = '0;
        full_d    = 1'b1;
        // The last byte leaves on this same edge, so only earlier slots count as lost.
        overrun_d = full_q && !last;
      end else if (full_q) begin
        cnt_d = cnt_q + 2'd1;
        if (last) begin
          full_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  assign byte_o       = hold_q[cnt_q];
  assign byte_valid_o = full_q;
  assign overrun_o    = overrun_q;

endmodule

// File: rtl/receptor.sv
// 4-lane receive path. Un-stripes lane words into a byte stream, then aligns on COM and
// classifies each byte (control_dk) while tracking STP/SDP ... END/EDB packet framing.
// Optional build macro: RX_SKP_PASS_EN forwards SKP outside packets (dk=2) rather than
// dropping it.
//   clk, rst           : clock, asynchronous active-low reset
//   enb                : enable; low freezes state, rx_ValidS and pulses read 0
//   rx_lane0..3        : lane bytes, rx_lanes_valid strobes a new word
//   com .. idle        : control symbol codes (quasi-static)
//   rx_DataS/ValidS    : un-striped byte and its valid
//   rx_control_dk      : classification of rx_DataS
//   rx_aligned         : COM has been seen since reset
//   rx_pkt_start/end/bad, rx_overrun : one-cycle pulses
module receptor
  import receptor_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [DATA_W-1:0] rx_lane0,
  input  logic [DATA_W-1:0] rx_lane1,
  input  logic [DATA_W-1:0] rx_lane2,
  input  logic [DATA_W-1:0] rx_lane3,
  input  logic              rx_lanes_valid,
  input  logic [DATA_W-1:0] com,
  input  logic [DATA_W-1:0] skp,
  input  logic [DATA_W-1:0] stp,
  input  logic [DATA_W-1:0] sdp,
  input  logic [DATA_W-1:0] end_ok,
  input  logic [DATA_W-1:0] edb,
  input  logic [DATA_W-1:0] fts,
  input  logic [DATA_W-1:0] idle,
  output logic [DATA_W-1:0] rx_DataS,
  output logic              rx_ValidS,
  output logic [CTRL_W-1:0] rx_control_dk,
  output logic              rx_aligned,
  output logic              rx_pkt_start,
  output logic              rx_pkt_end,
  output logic              rx_pkt_bad,
  output logic              rx_overrun
);

  logic [NUM_LANES-1:0][DATA_W-1:0] lanes;
  logic [DATA_W-1:0]                in_byte;
  logic                             in_valid;
  logic [CTRL_W-1:0]                code_dk;

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] dk_q, dk_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              bad_q, bad_d;

  assign lanes = {rx_lane3, rx_lane2, rx_lane1, rx_lane0};

  receptor_byte_unstriping #(
    .DATA_W (DATA_W)
  ) u_unstripe (
    .clk_i         (clk),
    .rst_ni        (rst),
    .enb_i         (enb),
    .lanes_i       (lanes),
    .lanes_valid_i (rx_lanes_valid),
    .byte_o        (in_byte),
    .byte_valid_o  (in_valid),
    .overrun_o     (rx_overrun)
  );

  // Full-table lookup; priority order makes the lower dk win when codes collide.
  always_comb begin
    code_dk = CTRL_W'(DK_DATA);
    if      (in_byte == com)    code_dk = CTRL_W'(DK_COM);
    else if (in_byte == skp)    code_dk = CTRL_W'(DK_SKP);
    else if (in_byte == stp)    code_dk = CTRL_W'(DK_STP);
    else if (in_byte == sdp)    code_dk = CTRL_W'(DK_SDP);
    else if (in_byte == end_ok) code_dk = CTRL_W'(DK_END);
    else if (in_byte == edb)    code_dk = CTRL_W'(DK_EDB);
    else if (in_byte == fts)    code_dk = CTRL_W'(DK_FTS);
    else if (in_byte == idle)   code_dk = CTRL_W'(DK_IDLE);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dk_d    = dk_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    bad_d   = 1'b0;
    if (enb && in_valid) begin
      case (state_q)
        StUnaligned: begin
          if (in_byte == com) begin
            state_d = StAligned;
            valid_d = 1'b1;
            data_d  = in_byte;
            dk_d    = CTRL_W'(DK_COM);
          end
        end
        StAligned: begin
          if (code_dk == CTRL_W'(DK_SKP)) begin
`ifdef RX_SKP_PASS_EN
            valid_d = 1'b1;
            data_d  = in_byte;
            dk_d    = code_dk;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = in_byte;
            dk_d    = code_dk;
            if (code_dk == CTRL_W'(DK_STP) || code_dk == CTRL_W'(DK_SDP)) begin
              state_d = StInPkt;
              start_d = 1'b1;
            end
          end
        end
        StInPkt: begin
          // Inside a packet only the terminators are control symbols.
          valid_d = 1'b1;
          data_d  = in_byte;
          dk_d    = CTRL_W'(DK_DATA);
          if (in_byte == end_ok) begin
            state_d = StAligned;
            dk_d    = CTRL_W'(DK_END);
            end_d   = 1'b1;
          end else if (in_byte == edb) begin
            state_d = StAligned;
            dk_d    = CTRL_W'(DK_EDB);
            end_d   = 1'b1;
            bad_d   = 1'b1;
          end
        end
        default: state_d = StUnaligned;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StUnaligned;
      data_q  <= '0;
      dk_q    <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dk_q    <= dk_d;
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
      bad_q   <= bad_d;
    end
  end

  assign rx_DataS      = data_q;
  assign rx_control_dk = dk_q;
  assign rx_ValidS     = valid_q;
  assign rx_pkt_start  = start_q;
  assign rx_pkt_end    = end_q;
  assign rx_pkt_bad    = bad_q;
  assign rx_aligned    = (state_q != StUnaligned);

endmodule
